// File: rtl/pipe_obuf_if.sv
// rtl/pipe_obuf_if.sv - handshake bundle between a pipeline stage and its output buffer
interface pipe_obuf_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d_out;
  logic [CW-1:0]    count;

  modport master (
    output flush, in_valid, d_in, out_ready,
    input  in_ready, out_valid, d_out, count
  );

  modport slave (
    input  flush, in_valid, d_in, out_ready,
    output in_ready, out_valid, d_out, count
  );
endinterface

// File: rtl/pipe_obuf.sv
// rtl/pipe_obuf.sv - elastic output buffer between pipeline stages
// DEPTH-entry circular buffer with flush, or pure wiring when FF_EN=0.
module pipe_obuf #(
  parameter int       WIDTH = 32,
  parameter int       DEPTH = 2,
  parameter bit [0:0] FF_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  pipe_obuf_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  generate
    if (FF_EN) begin : g_buf
      logic [WIDTH-1:0] r_mem [DEPTH];
      logic [PW-1:0]    r_wr_ptr;
      logic [PW-1:0]    r_rd_ptr;
      logic [CW-1:0]    r_count;
      logic             w_in_ready;
      logic             w_out_valid;
      logic             w_push;
      logic             w_pop;

      // in_ready looks only at occupancy, so a full buffer never takes a word on a pop cycle
      assign w_in_ready  = (r_count != CW'(DEPTH));
      assign w_out_valid = (r_count != '0);
      assign w_push      = bus.in_valid & w_in_ready & ~bus.flush;
      assign w_pop       = w_out_valid & bus.out_ready & ~bus.flush;

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else if (bus.flush) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_push) begin
            r_mem[r_wr_ptr] <= bus.d_in;
            r_wr_ptr        <= f_next(r_wr_ptr);
          end
          if (w_pop) r_rd_ptr <= f_next(r_rd_ptr);
          case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
          endcase
        end
      end

      assign bus.in_ready  = w_in_ready;
      assign bus.out_valid = w_out_valid;
      assign bus.d_out     = r_mem[r_rd_ptr];
      assign bus.count     = r_count;
    end else begin : g_pass
      logic w_unused;
      assign w_unused      = ^{clk, rst, bus.flush};
      assign bus.out_valid = bus.in_valid;
      assign bus.in_ready  = bus.out_ready;
      assign bus.d_out     = bus.d_in;
      assign bus.count     = '0;
    end
  endgenerate
endmodule

// File: tb/tb_pipe_obuf.sv
// tb/tb_pipe_obuf.sv - directed self-checking bench for pipe_obuf
module tb_pipe_obuf;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipe_obuf_if #(.WIDTH(32), .DEPTH(2)) b2 ();
  pipe_obuf_if #(.WIDTH(32), .DEPTH(3)) b3 ();
  pipe_obuf_if #(.WIDTH(32), .DEPTH(1)) b1 ();
  pipe_obuf_if #(.WIDTH(32), .DEPTH(4)) b4 ();
  pipe_obuf_if #(.WIDTH(32), .DEPTH(2)) bp ();

  pipe_obuf #(.WIDTH(32), .DEPTH(2), .FF_EN(1'b1)) u_d2 (.clk(clk), .rst(rst), .bus(b2));
  pipe_obuf #(.WIDTH(32), .DEPTH(3), .FF_EN(1'b1)) u_d3 (.clk(clk), .rst(rst), .bus(b3));
  pipe_obuf #(.WIDTH(32), .DEPTH(1), .FF_EN(1'b1)) u_d1 (.clk(clk), .rst(rst), .bus(b1));
  pipe_obuf #(.WIDTH(32), .DEPTH(4), .FF_EN(1'b1)) u_d4 (.clk(clk), .rst(rst), .bus(b4));
  pipe_obuf #(.WIDTH(32), .DEPTH(2), .FF_EN(1'b0)) u_pt (.clk(clk), .rst(rst), .bus(bp));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] fexp [4];
  logic        push_now;
  int          pops;
  int          n;
  int          k;
  logic [2:0]  pv [4];

  initial begin
    fexp = '{32'hA, 32'hB, 32'hC, 32'hD};
    pv   = '{3'b000, 3'b100, 3'b010, 3'b111};
    {b2.flush, b2.in_valid, b2.out_ready} = 3'b000; b2.d_in = '0;
    {b3.flush, b3.in_valid, b3.out_ready} = 3'b000; b3.d_in = '0;
    {b1.flush, b1.in_valid, b1.out_ready} = 3'b000; b1.d_in = '0;
    {b4.flush, b4.in_valid, b4.out_ready} = 3'b000; b4.d_in = '0;
    {bp.flush, bp.in_valid, bp.out_ready} = 3'b000; bp.d_in = '0;
    rst = 1'b1;

    // reset held with live upstream traffic
    b2.in_valid = 1'b1;
    b2.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      b2.d_in = $urandom;
      @(negedge clk);
      chk("rst_out_valid", 32'(b2.out_valid), 32'd0);
      chk("rst_count", 32'(b2.count), 32'd0);
      chk("rst_d_out", b2.d_out, 32'd0);
    end
    step();
    rst = 1'b0;
    b2.in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(b2.out_valid), 32'd0);
    chk("post_rst_in_ready", 32'(b2.in_ready), 32'd1);
    chk("post_rst_count", 32'(b2.count), 32'd0);
    chk("post_rst_d_out", b2.d_out, 32'd0);
    step();

    // streaming through DEPTH=2
    pops = 0;
    for (int i = 0; i < 9; i++) begin
      b2.in_valid = (i < 8);
      b2.d_in = 32'(i + 1);
      @(negedge clk);
      if (i > 0) begin
        chk("stream_d_out", b2.d_out, 32'(i));
        chk("stream_count", 32'(b2.count), 32'd1);
      end else begin
        chk("stream_count0", 32'(b2.count), 32'd0);
      end
      if (b2.out_valid && b2.out_ready) pops++;
      step();
    end
    b2.in_valid = 1'b0;
    chk("stream_pops", 32'(pops), 32'd8);
    @(negedge clk);
    chk("stream_empty", 32'(b2.out_valid), 32'd0);
    step();

    // fill under stall, then drain with wrap, DEPTH=3
    b3.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b3.in_valid = 1'b1;
      b3.d_in = fexp[i];
      step();
    end
    b3.d_in = fexp[3];
    @(negedge clk);
    chk("fill_count", 32'(b3.count), 32'd3);
    chk("fill_in_ready", 32'(b3.in_ready), 32'd0);
    chk("fill_head", b3.d_out, 32'hA);
    step();
    @(negedge clk);
    chk("fill_hold_off", 32'(b3.count), 32'd3);
    step();
    b3.out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 12 && n < 4; c++) begin
      @(negedge clk);
      push_now = b3.in_valid & b3.in_ready;
      if (b3.out_valid) begin
        chk("fill_order", b3.d_out, fexp[n]);
        n++;
      end
      step();
      if (push_now) b3.in_valid = 1'b0;
    end
    chk("fill_n_popped", 32'(n), 32'd4);
    @(negedge clk);
    chk("fill_drained", 32'(b3.out_valid), 32'd0);
    step();

    // reset mid-stream drops held entries
    b3.out_ready = 1'b0;
    b3.in_valid = 1'b1;
    b3.d_in = 32'h77;
    step();
    b3.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_count", 32'(b3.count), 32'd0);
    chk("midrst_d_out", b3.d_out, 32'd0);
    step();

    // DEPTH=1 continuous traffic: one word per two cycles
    b1.out_ready = 1'b1;
    b1.in_valid = 1'b1;
    k = 0;
    b1.d_in = 32'h10;
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("d1_in_ready", 32'(b1.in_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (b1.out_valid && b1.out_ready) begin
        chk("d1_data", b1.d_out, 32'h10 + 32'(pops));
        pops++;
      end
      push_now = b1.in_valid & b1.in_ready;
      step();
      if (push_now) begin
        k++;
        b1.d_in = 32'h10 + 32'(k);
      end
    end
    b1.in_valid = 1'b0;
    chk("d1_pops", 32'(pops), 32'd4);

    // DEPTH=4 continuous traffic: one word per cycle
    b4.out_ready = 1'b1;
    b4.in_valid = 1'b1;
    k = 0;
    b4.d_in = 32'h10;
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("d4_in_ready", 32'(b4.in_ready), 32'd1);
      if (b4.out_valid && b4.out_ready) begin
        chk("d4_data", b4.d_out, 32'h10 + 32'(pops));
        pops++;
      end
      push_now = b4.in_valid & b4.in_ready;
      step();
      if (push_now) begin
        k++;
        b4.d_in = 32'h10 + 32'(k);
      end
    end
    b4.in_valid = 1'b0;
    chk("d4_pops", 32'(pops), 32'd7);
    @(negedge clk);
    chk("d4_last", b4.d_out, 32'h17);
    step();

    // flush wins over simultaneous push and pop
    b4.out_ready = 1'b0;
    b4.in_valid = 1'b1;
    b4.d_in = 32'h21;
    step();
    b4.d_in = 32'h22;
    step();
    b4.d_in = 32'h23;
    b4.out_ready = 1'b1;
    b4.flush = 1'b1;
    @(negedge clk);
    chk("flush_pre_count", 32'(b4.count), 32'd2);
    step();
    b4.flush = 1'b0;
    b4.in_valid = 1'b0;
    b4.out_ready = 1'b0;
    @(negedge clk);
    chk("flush_count", 32'(b4.count), 32'd0);
    chk("flush_out_valid", 32'(b4.out_valid), 32'd0);
    step();
    b4.in_valid = 1'b1;
    b4.d_in = 32'h44;
    step();
    b4.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_next_valid", 32'(b4.out_valid), 32'd1);
    chk("flush_next_data", b4.d_out, 32'h44);
    chk("flush_next_count", 32'(b4.count), 32'd1);

    // pass-through mirrors both sides combinationally
    for (int i = 0; i < 4; i++) begin
      bp.in_valid = pv[i][2];
      bp.out_ready = pv[i][1];
      bp.d_in = pv[i][0] ? 32'hA5A5A5A5 : 32'h5A5A5A5A;
      #1;
      chk("pt_out_valid", 32'(bp.out_valid), 32'(pv[i][2]));
      chk("pt_in_ready", 32'(bp.in_ready), 32'(pv[i][1]));
      chk("pt_d_out", bp.d_out, pv[i][0] ? 32'hA5A5A5A5 : 32'h5A5A5A5A);
      chk("pt_count", 32'(bp.count), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
